// File: rtl/query_stream_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// fieldious_io_pkg
// Shared types and helpers for the write-clock-domain query load path.
//   state_t : load FSM states (IDLE, COLLECT, DONE)
//   beats() : number of pad beats needed to cover one assembled word
// ---------------------------------------------------------------------------
package fieldious_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Ceiling division: a partial final beat still costs a full beat.
  function automatic int beats(input int data_width, input int io_width);
    return (data_width + io_width - 1) / io_width;
  endfunction

endpackage

// File: rtl/query_stream_deserializer_if.sv
// ---------------------------------------------------------------------------
// query_stream_deserializer_if
// Bundles the pad beat handshake and the async_fifo1 write port.
//   io_valid / io_data / io_ready : narrow beats from the chip pads
//   fifo_wdata / fifo_winc        : word and write strobe toward async_fifo1
//   fifo_wfull                    : async_fifo1 full flag (write domain)
// Modports:
//   slave  : the deserializer (consumes beats, drives the fifo write port)
//   master : the environment (pads + fifo)
// ---------------------------------------------------------------------------
interface query_stream_deserializer_if #(
  parameter int DATA_WIDTH = 11,
  parameter int IO_WIDTH   = 4
);

  logic                  io_valid;
  logic [IO_WIDTH-1:0]   io_data;
  logic                  io_ready;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;

  modport master (
    output io_valid, io_data, fifo_wfull,
    input  io_ready, fifo_wdata, fifo_winc
  );

  modport slave (
    input  io_valid, io_data, fifo_wfull,
    output io_ready, fifo_wdata, fifo_winc
  );

endinterface

// File: rtl/query_stream_deserializer_io_beat_packer.sv
// ---------------------------------------------------------------------------
// io_beat_packer
// Assembles IO_WIDTH beats LSB-first into a DATA_WIDTH word.
// Only the non-final beats are stored; the final beat is merged
// combinationally so the word is available on the same edge that accepts it.
// Ports:
//   wclk, wrst_n : write clock, synchronous active-low reset
//   beat_en      : a beat is accepted on this edge
//   clear        : drop any partial word and restart at beat 0
//   beat_data    : incoming pad beat
//   final_beat   : the next accepted beat completes a word
//   word         : assembled word (valid when word_done)
//   word_done    : a word completes on this edge
// Assumes the word spans at least two beats.
// ---------------------------------------------------------------------------
module io_beat_packer
  import fieldious_io_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int IO_WIDTH   = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  beat_en,
  input  logic                  clear,
  input  logic [IO_WIDTH-1:0]   beat_data,
  output logic                  final_beat,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int BEATS  = beats(DATA_WIDTH, IO_WIDTH);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BUF_W  = (BEATS - 1) * IO_WIDTH;
  localparam int PACK_W = BEATS * IO_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PACK_W-1:0] packed_word;

  assign final_beat  = (beat_cnt_q == LAST_BEAT);
  assign word_done   = beat_en && final_beat;
  assign packed_word = {beat_data, buf_q};
  assign word        = packed_word[DATA_WIDTH-1:0];

  // Final-beat bits above the word width are intentionally dropped.
  if (PACK_W > DATA_WIDTH) begin : g_trim
    logic unused_hi_bits;
    assign unused_hi_bits = ^packed_word[PACK_W-1:DATA_WIDTH];
  end

  always_comb begin
    buf_d      = buf_q;
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      buf_d      = '0;
      beat_cnt_d = '0;
    end else if (beat_en) begin
      if (final_beat) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_cnt_q == CNT_W'(k)) begin
            buf_d[k*IO_WIDTH +: IO_WIDTH] = beat_data;
          end
        end
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      buf_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/query_stream_deserializer.sv
// ---------------------------------------------------------------------------
// query_stream_deserializer
// Write-domain front end of the query path: packs pad beats into words and
// writes one frame of FRAME_WORDS words into async_fifo1, then stops.
// Ports:
//   wclk, wrst_n  : write clock, synchronous active-low reset
//   load_enable   : top FSM is in the query-load phase
//   bus (slave)   : pad beat handshake + async_fifo1 write port
//   frame_done    : one-cycle pulse after the last word of a frame is written
//   abort_err     : sticky, load_enable dropped mid-frame (cleared by reset)
//   words_written : words written in the current frame (saturating)
// ---------------------------------------------------------------------------
module query_stream_deserializer
  import fieldious_io_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int IO_WIDTH    = 4,
  parameter int FRAME_WORDS = 640
) (
  input  logic                             wclk,
  input  logic                             wrst_n,
  input  logic                             load_enable,
  query_stream_deserializer_if.slave       bus,
  output logic                             frame_done,
  output logic                             abort_err,
  output logic [$clog2(FRAME_WORDS+1)-1:0] words_written
);

  localparam int WW = $clog2(FRAME_WORDS + 1);

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WW-1:0]         words_q, words_d;
  logic                  abort_q, abort_d;
  logic                  frame_done_q, frame_done_d;

  logic                  io_ready;
  logic                  fifo_winc;
  logic                  beat_en;
  logic                  pack_clear;
  logic                  final_beat;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] packed_word;
  logic                  frame_full;

  // The packer restarts at beat 0 whenever we are not actively collecting.
  assign pack_clear = (state_q != COLLECT) || !load_enable;
  assign beat_en    = bus.io_valid && io_ready;

  io_beat_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IO_WIDTH   (IO_WIDTH)
  ) u_packer (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .beat_en    (beat_en),
    .clear      (pack_clear),
    .beat_data  (bus.io_data),
    .final_beat (final_beat),
    .word       (packed_word),
    .word_done  (word_done)
  );

  // Every word of the frame is either written or sitting in the skid register.
  assign frame_full = (({1'b0, words_q} + {{WW{1'b0}}, out_valid_q}) == (WW+1)'(FRAME_WORDS));

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    wdata_d      = wdata_q;
    words_d      = words_q;
    abort_d      = abort_q;
    frame_done_d = 1'b0;
    fifo_winc    = out_valid_q && !bus.fifo_wfull;
    io_ready     = 1'b0;

    // Non-final beats always land in the packer; the final beat needs room
    // in the skid register, which frees up on the same edge as a fifo write.
    if (state_q == COLLECT && !frame_full) begin
      io_ready = final_beat ? (!out_valid_q || !bus.fifo_wfull) : 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load_enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!load_enable) begin
          state_d     = IDLE;
          abort_d     = 1'b1;
          out_valid_d = 1'b0;
          words_d     = '0;
        end else begin
          if (fifo_winc) begin
            out_valid_d = 1'b0;
            words_d     = (words_q == WW'(FRAME_WORDS)) ? words_q : words_q + 1'b1;
            if (words_q == WW'(FRAME_WORDS - 1)) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end
          end
          // A word loading on the same edge as a write replaces the old one.
          if (word_done) begin
            wdata_d     = packed_word;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!load_enable) begin
          state_d = IDLE;
          words_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      wdata_q      <= '0;
      words_q      <= '0;
      abort_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      wdata_q      <= wdata_d;
      words_q      <= words_d;
      abort_q      <= abort_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.io_ready   = io_ready;
  assign bus.fifo_winc  = fifo_winc;
  assign bus.fifo_wdata = wdata_q;
  assign frame_done     = frame_done_q;
  assign abort_err      = abort_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_query_stream_deserializer.sv
// ---------------------------------------------------------------------------
// tb_query_stream_deserializer
// Directed bench for query_stream_deserializer with FRAME_WORDS=4.
// ---------------------------------------------------------------------------
module tb_query_stream_deserializer;

  localparam int DW = 11;
  localparam int IW = 4;
  localparam int FW = 4;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       load_enable;
  logic       frame_done;
  logic       abort_err;
  logic [2:0] words_written;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] writes[$];
  int            fd_count = 0;

  query_stream_deserializer_if #(.DATA_WIDTH(DW), .IO_WIDTH(IW)) bus ();

  query_stream_deserializer #(
    .DATA_WIDTH  (DW),
    .IO_WIDTH    (IW),
    .FRAME_WORDS (FW)
  ) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .load_enable   (load_enable),
    .bus           (bus),
    .frame_done    (frame_done),
    .abort_err     (abort_err),
    .words_written (words_written)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic          le;
    logic          v;
    logic [IW-1:0] d;
    logic          wf;
    logic          rdy;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          fd;
    logic          ab;
    logic [2:0]    words;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic le, v, input logic [IW-1:0] d, input logic wf,
                                 input logic rdy, winc, input logic [DW-1:0] wdata,
                                 input logic fd, ab, input logic [2:0] words);
    vec_t r;
    r.le = le; r.v = v; r.d = d; r.wf = wf;
    r.rdy = rdy; r.winc = winc; r.wdata = wdata; r.fd = fd; r.ab = ab; r.words = words;
    vecs.push_back(r);
  endfunction

  // Record every fifo write and frame_done pulse; a write while full is illegal.
  always @(negedge wclk) begin
    if (wrst_n && bus.fifo_winc) writes.push_back(bus.fifo_wdata);
    if (wrst_n && frame_done) fd_count++;
    if (wrst_n && bus.fifo_winc && bus.fifo_wfull) begin
      fails++;
      $display("[TB] FAIL winc_while_full: winc=1 wfull=1 required winc=0");
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive inputs just after the active edge, then move to the sampling edge.
  task automatic applyStimulus(input logic le, v, input logic [IW-1:0] d, input logic wf);
    @(posedge wclk);
    #1;
    load_enable    = le;
    bus.io_valid   = v;
    bus.io_data    = d;
    bus.fifo_wfull = wf;
    @(negedge wclk);
  endtask

  // Present a beat and hold it until io_ready is seen; the next edge takes it.
  task automatic sendBeat(input logic [IW-1:0] d, input logic wf);
    int waited = 0;
    applyStimulus(1'b1, 1'b1, d, wf);
    while (!bus.io_ready && waited < 20) begin
      @(posedge wclk);
      #1;
      @(negedge wclk);
      waited++;
    end
    if (!bus.io_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL beat_timeout: io_ready=0 after %0d cycles, required 1", waited);
    end
  endtask

  task automatic checkWrites(input string name, input logic [DW-1:0] exp[$]);
    checkOutput({name, "_count"}, writes.size(), exp.size());
    for (int i = 0; i < exp.size() && i < writes.size(); i++)
      checkOutput($sformatf("%s_word%0d", name, i), 32'(writes[i]), 32'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wrst_n         = 1'b0;
    load_enable    = 1'b0;
    bus.io_valid   = 1'b1;
    bus.io_data    = 4'hF;
    bus.fifo_wfull = 1'b0;

    // Reset values with io_valid already high.
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    checkOutput("rst_io_ready", 32'(bus.io_ready), 0);
    checkOutput("rst_winc", 32'(bus.fifo_winc), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_words", 32'(words_written), 0);
    checkOutput("rst_wdata", 32'(bus.fifo_wdata), 0);
    checkOutput("rst_abort", 32'(abort_err), 0);
    @(posedge wclk);
    #1 wrst_n = 1'b1;

    // Full frame 0x73B, 0x5A1, 0x7FF, 0x000 at one beat per cycle.
    //      le v  d     wf   rdy winc wdata   fd ab words
    addVec(0, 1, 4'h0, 0,   0,  0,   11'h000, 0, 0, 0);
    addVec(1, 1, 4'hB, 0,   0,  0,   11'h000, 0, 0, 0);
    addVec(1, 1, 4'hB, 0,   1,  0,   11'h000, 0, 0, 0);
    addVec(1, 1, 4'h3, 0,   1,  0,   11'h000, 0, 0, 0);
    addVec(1, 1, 4'h7, 0,   1,  0,   11'h000, 0, 0, 0);
    addVec(1, 1, 4'h1, 0,   1,  1,   11'h73B, 0, 0, 0);
    addVec(1, 1, 4'hA, 0,   1,  0,   11'h73B, 0, 0, 1);
    addVec(1, 1, 4'h5, 0,   1,  0,   11'h73B, 0, 0, 1);
    addVec(1, 1, 4'hF, 0,   1,  1,   11'h5A1, 0, 0, 1);
    addVec(1, 1, 4'hF, 0,   1,  0,   11'h5A1, 0, 0, 2);
    addVec(1, 1, 4'h7, 0,   1,  0,   11'h5A1, 0, 0, 2);
    addVec(1, 1, 4'h0, 0,   1,  1,   11'h7FF, 0, 0, 2);
    addVec(1, 1, 4'h0, 0,   1,  0,   11'h7FF, 0, 0, 3);
    addVec(1, 1, 4'h0, 0,   1,  0,   11'h7FF, 0, 0, 3);
    addVec(1, 1, 4'h0, 0,   0,  1,   11'h000, 0, 0, 3);
    addVec(1, 1, 4'h0, 0,   0,  0,   11'h000, 1, 0, 4);
    addVec(1, 1, 4'h0, 0,   0,  0,   11'h000, 0, 0, 4);
    addVec(0, 0, 4'h0, 0,   0,  0,   11'h000, 0, 0, 4);
    addVec(0, 0, 4'h0, 0,   0,  0,   11'h000, 0, 0, 0);

    $display("[TB] table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].le, vecs[i].v, vecs[i].d, vecs[i].wf);
      checkOutput($sformatf("row%0d_io_ready", i), 32'(bus.io_ready), 32'(vecs[i].rdy));
      checkOutput($sformatf("row%0d_winc", i), 32'(bus.fifo_winc), 32'(vecs[i].winc));
      checkOutput($sformatf("row%0d_wdata", i), 32'(bus.fifo_wdata), 32'(vecs[i].wdata));
      checkOutput($sformatf("row%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      checkOutput($sformatf("row%0d_abort", i), 32'(abort_err), 32'(vecs[i].ab));
      checkOutput($sformatf("row%0d_words", i), 32'(words_written), 32'(vecs[i].words));
    end

    // fifo_wfull held high while the next word is half collected.
    $display("[TB] wfull stall sequence");
    writes.delete();
    fd_count = 0;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    sendBeat(4'h1, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    sendBeat(4'h2, 1'b1); sendBeat(4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 4'h0, 1'b1);
      checkOutput($sformatf("stall%0d_io_ready", i), 32'(bus.io_ready), 0);
      checkOutput($sformatf("stall%0d_winc", i), 32'(bus.fifo_winc), 0);
      checkOutput($sformatf("stall%0d_wdata", i), 32'(bus.fifo_wdata), 32'h001);
    end
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b0);
    checkOutput("release_io_ready", 32'(bus.io_ready), 1);
    checkOutput("release_winc", 32'(bus.fifo_winc), 1);
    checkOutput("release_wdata", 32'(bus.fifo_wdata), 32'h001);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("swap_winc", 32'(bus.fifo_winc), 1);
    checkOutput("swap_wdata", 32'(bus.fifo_wdata), 32'h002);
    sendBeat(4'h3, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    sendBeat(4'h4, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 4'h0, 1'b0);
    checkOutput("frame_end_io_ready", 32'(bus.io_ready), 0);
    checkOutput("frame_end_words", 32'(words_written), 4);
    checkOutput("frame_end_fd_count", 32'(fd_count), 1);
    checkWrites("stall_frame", '{11'h001, 11'h002, 11'h003, 11'h004});
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("done_idle_words", 32'(words_written), 0);

    // load_enable dropped after two words with a partial third word pending.
    $display("[TB] abort sequence");
    writes.delete();
    fd_count = 0;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    sendBeat(4'h5, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    sendBeat(4'h6, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("pre_abort_words", 32'(words_written), 2);
    checkOutput("pre_abort_flag", 32'(abort_err), 0);
    sendBeat(4'h7, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("abort_flag", 32'(abort_err), 1);
    checkOutput("abort_words", 32'(words_written), 0);
    checkOutput("abort_io_ready", 32'(bus.io_ready), 0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    sendBeat(4'h8, 1'b0); sendBeat(4'h0, 1'b0); sendBeat(4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkWrites("abort_frame", '{11'h005, 11'h006, 11'h008});
    checkOutput("abort_sticky", 32'(abort_err), 1);
    checkOutput("restart_words", 32'(words_written), 1);
    checkOutput("abort_fd_count", 32'(fd_count), 0);

    // Only reset clears the sticky abort flag.
    @(posedge wclk);
    #1 wrst_n = 1'b0;
    load_enable = 1'b0;
    @(posedge wclk);
    @(negedge wclk);
    checkOutput("reset_clears_abort", 32'(abort_err), 0);
    checkOutput("reset_clears_words", 32'(words_written), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
